voq_mgr: RTL and testbench

VOQ_MGR -- requirements
Module: voq_mgr

---
 rtl/voq_mgr.sv | 141 ++++++++++++++
 tb/tb_voq_mgr.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/voq_mgr.sv
// Virtual output queue manager: NUM_PORTS descriptor FIFOs sharing one
// statically partitioned simple dual-port RAM, with flush and drop accounting.
module voq_mgr #(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned QUEUE_DEPTH = 64,
    parameter int unsigned ADDR_WIDTH  = 10,
    localparam int unsigned SEL_W      = $clog2(NUM_PORTS),
    localparam int unsigned CNT_W      = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enq_en,
    input  logic [SEL_W-1:0]           enq_sel,
    input  logic [ADDR_WIDTH-1:0]      enq_addr,
    input  logic                       deq_en,
    input  logic [SEL_W-1:0]           deq_sel,
    input  logic                       flush_en,
    input  logic [SEL_W-1:0]           flush_sel,
    output logic                       deq_valid,
    output logic [ADDR_WIDTH-1:0]      deq_addr,
    output logic [NUM_PORTS-1:0]       is_empty,
    output logic [NUM_PORTS-1:0]       is_full,
    output logic [NUM_PORTS*CNT_W-1:0] occupancy,
    output logic [15:0]                drop_count
);

    localparam int unsigned PTR_W     = $clog2(QUEUE_DEPTH);
    localparam int unsigned MEM_AW    = SEL_W + PTR_W;
    localparam int unsigned MEM_WORDS = NUM_PORTS * QUEUE_DEPTH;

    logic [ADDR_WIDTH-1:0] mem   [MEM_WORDS];
    logic [PTR_W-1:0]      head  [NUM_PORTS];
    logic [PTR_W-1:0]      tail  [NUM_PORTS];
    logic [CNT_W-1:0]      count [NUM_PORTS];

    logic                  enq_flushed;
    logic                  deq_flushed;
    logic                  enq_ok;
    logic                  deq_ok;
    logic                  enq_drop;
    logic [MEM_AW-1:0]     wr_addr;
    logic [MEM_AW-1:0]     rd_addr;
    logic [NUM_PORTS-1:0]  enq_hit;
    logic [NUM_PORTS-1:0]  deq_hit;
    logic [NUM_PORTS-1:0]  flush_hit;

    // Acceptance decisions from pre-edge state; a flush masks same-queue requests.
    always_comb begin
        enq_flushed = flush_en && (flush_sel == enq_sel);
        deq_flushed = flush_en && (flush_sel == deq_sel);
        deq_ok      = deq_en && !deq_flushed && (count[deq_sel] != '0);
        enq_ok      = enq_en && !enq_flushed &&
                      ((count[enq_sel] != CNT_W'(QUEUE_DEPTH)) ||
                       (deq_ok && (deq_sel == enq_sel)));
        enq_drop    = enq_en && !enq_flushed && !enq_ok;
        wr_addr     = {enq_sel, tail[enq_sel]};
        rd_addr     = {deq_sel, head[deq_sel]};
    end

    always_comb begin
        enq_hit   = '0;
        deq_hit   = '0;
        flush_hit = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            enq_hit[i]   = enq_ok && (enq_sel == SEL_W'(i));
            deq_hit[i]   = deq_ok && (deq_sel == SEL_W'(i));
            flush_hit[i] = flush_en && (flush_sel == SEL_W'(i));
        end
    end

    // Descriptor storage: queue i owns the block whose upper address bits equal i.
    always_ff @(posedge clk) begin
        if (enq_ok) begin
            mem[wr_addr] <= enq_addr;
        end
    end

    // Registered read port; a same-cycle write to a full queue's head returns the old word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deq_valid <= 1'b0;
            deq_addr  <= '0;
        end else begin
            deq_valid <= deq_ok;
            if (deq_ok) begin
                deq_addr <= mem[rd_addr];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (flush_hit[i]) begin
                    head[i]  <= '0;
                    tail[i]  <= '0;
                    count[i] <= '0;
                end else begin
                    if (enq_hit[i]) begin
                        tail[i] <= tail[i] + PTR_W'(1);
                    end
                    if (deq_hit[i]) begin
                        head[i] <= head[i] + PTR_W'(1);
                    end
                    case ({enq_hit[i], deq_hit[i]})
                        2'b10:   count[i] <= count[i] + CNT_W'(1);
                        2'b01:   count[i] <= count[i] - CNT_W'(1);
                        default: count[i] <= count[i];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (enq_drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    // Scheduler-facing status, combinational from registered counts.
    always_comb begin
        is_empty  = '0;
        is_full   = '0;
        occupancy = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            is_empty[i]                  = (count[i] == '0);
            is_full[i]                   = (count[i] == CNT_W'(QUEUE_DEPTH));
            occupancy[i*CNT_W +: CNT_W]  = count[i];
        end
    end

endmodule

// File: tb/tb_voq_mgr.sv
// Directed bench for voq_mgr against a queue-level reference model.
module tb_voq_mgr;

    localparam int unsigned NP = 4;
    localparam int unsigned QD = 64;
    localparam int unsigned AW = 10;
    localparam int unsigned SW = 2;
    localparam int unsigned CW = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             enq_en;
    logic [SW-1:0]    enq_sel;
    logic [AW-1:0]    enq_addr;
    logic             deq_en;
    logic [SW-1:0]    deq_sel;
    logic             flush_en;
    logic [SW-1:0]    flush_sel;
    logic             deq_valid;
    logic [AW-1:0]    deq_addr;
    logic [NP-1:0]    is_empty;
    logic [NP-1:0]    is_full;
    logic [NP*CW-1:0] occupancy;
    logic [15:0]      drop_count;

    always #5 clk = ~clk;

    voq_mgr #(.NUM_PORTS(NP), .QUEUE_DEPTH(QD), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .enq_en(enq_en), .enq_sel(enq_sel), .enq_addr(enq_addr),
        .deq_en(deq_en), .deq_sel(deq_sel),
        .flush_en(flush_en), .flush_sel(flush_sel),
        .deq_valid(deq_valid), .deq_addr(deq_addr),
        .is_empty(is_empty), .is_full(is_full),
        .occupancy(occupancy), .drop_count(drop_count)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: one FIFO per queue plus the expected output registers.
    logic [AW-1:0] mq [NP][$];
    logic          m_valid;
    logic [AW-1:0] m_addr;
    logic [15:0]   m_drop;
    bit            chk_on = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NP; i++) mq[i].delete();
        m_valid = 1'b0;
        m_addr  = '0;
        m_drop  = '0;
    endfunction

    // Dequeue first so that a same-queue dequeue frees a slot for a full-queue enqueue.
    function automatic void model_step();
        bit d_ok;
        bit e_live;
        d_ok   = deq_en && (mq[deq_sel].size() != 0) && !(flush_en && flush_sel == deq_sel);
        e_live = enq_en && !(flush_en && flush_sel == enq_sel);
        m_valid = d_ok;
        if (d_ok) m_addr = mq[deq_sel].pop_front();
        if (e_live) begin
            if (mq[enq_sel].size() < QD) mq[enq_sel].push_back(enq_addr);
            else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
        if (flush_en) mq[flush_sel].delete();
    endfunction

    always @(negedge clk) begin
        logic [NP-1:0]    e_emp;
        logic [NP-1:0]    e_full;
        logic [NP*CW-1:0] e_occ;
        if (chk_on) begin
            for (int i = 0; i < NP; i++) begin
                e_emp[i]          = (mq[i].size() == 0);
                e_full[i]         = (mq[i].size() == QD);
                e_occ[i*CW +: CW] = CW'(mq[i].size());
            end
            check("deq_valid",  64'(deq_valid),  64'(m_valid));
            check("deq_addr",   64'(deq_addr),   64'(m_addr));
            check("is_empty",   64'(is_empty),   64'(e_emp));
            check("is_full",    64'(is_full),    64'(e_full));
            check("occupancy",  64'(occupancy),  64'(e_occ));
            check("drop_count", 64'(drop_count), 64'(m_drop));
        end
    end

    task automatic cyc(input logic ee, input logic [SW-1:0] es, input logic [AW-1:0] ea,
                       input logic de, input logic [SW-1:0] ds,
                       input logic fe, input logic [SW-1:0] fs);
        enq_en = ee; enq_sel = es; enq_addr = ea;
        deq_en = de; deq_sel = ds;
        flush_en = fe; flush_sel = fs;
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        @(negedge clk);
        enq_en = 1'b0; deq_en = 1'b0; flush_en = 1'b0;
    endtask

    task automatic enq(input int s, input int a);
        cyc(1'b1, SW'(s), AW'(a), 1'b0, '0, 1'b0, '0);
    endtask

    task automatic deq(input int s);
        cyc(1'b0, '0, '0, 1'b1, SW'(s), 1'b0, '0);
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        reset = 1'b1;
        enq_en = 1'b0; enq_sel = '0; enq_addr = '0;
        deq_en = 1'b0; deq_sel = '0; flush_en = 1'b0; flush_sel = '0;
        model_reset();
        chk_on = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_is_empty",  64'(is_empty),  64'(4'hF));
        check("rst_occupancy", 64'(occupancy), 64'(0));
        check("rst_deq_addr",  64'(deq_addr),  64'(0));
        reset = 1'b0;
        idle();

        // Two enqueues then back-to-back dequeues on queue 2.
        enq(2, 'h005);
        enq(2, 'h006);
        check("q2_occ2", 64'(occupancy[2*CW +: CW]), 64'(2));
        deq(2);
        check("b2b_valid0", 64'(deq_valid), 64'(1));
        check("b2b_addr0",  64'(deq_addr),  64'('h005));
        deq(2);
        check("b2b_valid1", 64'(deq_valid), 64'(1));
        check("b2b_addr1",  64'(deq_addr),  64'('h006));
        idle();
        check("b2b_valid_off", 64'(deq_valid), 64'(0));
        check("b2b_empty",     64'(is_empty),  64'(4'hF));

        // Fill queue 1, overflow once, drain in order; repeat from a shifted pointer.
        for (int i = 0; i < 64; i++) enq(1, i);
        check("q1_full", 64'(is_full[1]), 64'(1));
        enq(1, 'h3C0);
        check("q1_drop", 64'(drop_count), 64'(1));
        for (int i = 0; i < 64; i++) begin
            deq(1);
            check("q1_drain", 64'(deq_addr), 64'(i));
        end
        for (int k = 0; k < 3; k++) enq(1, 100 + k);
        for (int k = 0; k < 3; k++) deq(1);
        for (int i = 0; i < 64; i++) enq(1, i);
        check("q1_full_wrap", 64'(is_full[1]), 64'(1));
        for (int i = 0; i < 64; i++) begin
            deq(1);
            check("q1_drain_wrap", 64'(deq_addr), 64'(i));
        end
        idle();

        // Full queue 0 with simultaneous enqueue and dequeue.
        for (int i = 0; i < 64; i++) enq(0, 200 + i);
        cyc(1'b1, 2'd0, 10'h3FF, 1'b1, 2'd0, 1'b0, '0);
        check("q0_sim_addr", 64'(deq_addr), 64'(200));
        check("q0_sim_occ",  64'(occupancy[0*CW +: CW]), 64'(64));
        check("q0_sim_drop", 64'(drop_count), 64'(1));
        for (int i = 0; i < 64; i++) begin
            deq(0);
            if (i == 0)  check("q0_first", 64'(deq_addr), 64'(201));
            if (i == 63) check("q0_last",  64'(deq_addr), 64'('h3FF));
        end
        idle();

        // Empty-queue dequeue, then enqueue plus dequeue on empty queue 3.
        deq(3);
        check("q3_empty_valid", 64'(deq_valid), 64'(0));
        check("q3_empty_occ",   64'(occupancy), 64'(0));
        cyc(1'b1, 2'd3, 10'h055, 1'b1, 2'd3, 1'b0, '0);
        check("q3_nobypass_valid", 64'(deq_valid), 64'(0));
        check("q3_nobypass_occ",   64'(occupancy[3*CW +: CW]), 64'(1));

        // Flush queue 1 while enqueuing to it and dequeuing queue 0.
        for (int k = 0; k < 5; k++) enq(1, 'h020 + k);
        enq(0, 'h077);
        cyc(1'b1, 2'd1, 10'h012, 1'b1, 2'd0, 1'b1, 2'd1);
        check("flush_q1_empty", 64'(is_empty[1]), 64'(1));
        check("flush_q0_valid", 64'(deq_valid), 64'(1));
        check("flush_q0_addr",  64'(deq_addr), 64'('h077));
        check("flush_drop",     64'(drop_count), 64'(1));
        check("flush_q3_kept",  64'(occupancy[3*CW +: CW]), 64'(1));

        // Enqueue and dequeue on different queues in the same cycle.
        cyc(1'b1, 2'd2, 10'h044, 1'b1, 2'd3, 1'b0, '0);
        check("diff_addr",   64'(deq_addr), 64'('h055));
        check("diff_q2_occ", 64'(occupancy[2*CW +: CW]), 64'(1));

        // Reset while a dequeue result is being presented.
        enq(2, 'h031);
        deq(2);
        check("pre_rst_valid", 64'(deq_valid), 64'(1));
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("mid_rst_valid", 64'(deq_valid),  64'(0));
        check("mid_rst_occ",   64'(occupancy),  64'(0));
        check("mid_rst_empty", 64'(is_empty),   64'(4'hF));
        check("mid_rst_drop",  64'(drop_count), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle();
        idle();

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
